// File: rtl/ov7670_capture_pkg.sv
// Shared types and default geometry for the OV7670 pixel capture block.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    FRAME_END  = 2'd3
  } cap_state_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned ADDR_W_DEF   = 19;

endpackage

// File: rtl/ov7670_byte_pairer.sv
// Pairs consecutive camera bytes into RGB565 words; first byte is the high half.
module ov7670_byte_pairer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        flush,
  input  logic        accept,
  input  logic [7:0]  d_r,
  output logic        pair_c,
  output logic        partial_err_c,
  output logic [15:0] pixel_data,
  output logic        pixel_valid
);

  logic       phase;
  logic [7:0] hi_byte;
  logic       phase_nxt_c;

  // Pair completes on a phase-1 byte; a flush with a half pair pending is an error.
  always_comb begin
    pair_c        = enable & phase;
    phase_nxt_c   = enable ? ~phase : phase;
    partial_err_c = flush & phase_nxt_c;
  end

  // Phase toggle, high-byte latch and registered pixel strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= 1'b0;
      hi_byte     <= 8'd0;
      pixel_data  <= 16'd0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= pair_c & accept;
      if (pair_c && accept) begin
        pixel_data <= {hi_byte, d_r};
      end
      if (enable && !phase) begin
        hi_byte <= d_r;
      end
      if (clear || flush) begin
        phase <= 1'b0;
      end else begin
        phase <= phase_nxt_c;
      end
    end
  end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: registers the camera bus, tracks frames and
// emits RGB565 pixels with coordinates and a linear frame-buffer address.
// Optional 2:1 decimation in both axes when OV7670_CAPTURE_DECIMATE_EN is defined.
module ov7670_pixel_capture
  import ov7670_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_done,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pixel_data,
  output logic              pixel_valid,
  output logic [9:0]        pixel_x,
  output logic [8:0]        pixel_y,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              line_err,
  output logic              busy
);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int unsigned H_LIM = H_ACTIVE / 2;
  localparam int unsigned V_LIM = V_ACTIVE / 2;
`else
  localparam int unsigned H_LIM = H_ACTIVE;
  localparam int unsigned V_LIM = V_ACTIVE;
`endif

  cap_state_t        state;
  logic              v_r, h_r, v_r_d, h_r_d;
  logic [7:0]        d_r;
  logic [9:0]        x_cnt;
  logic [8:0]        y_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  logic cap_c, v_fall_c, v_rise_c, h_fall_c, start_c, flush_c;
  logic pair_c, partial_err_c, keep_c, in_range_c, accept_c, y_step_c;

  // Single registration of the camera bus plus one-cycle history for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_r   <= 1'b0;
      h_r   <= 1'b0;
      d_r   <= 8'd0;
      v_r_d <= 1'b0;
      h_r_d <= 1'b0;
    end else begin
      v_r   <= cam_vsync;
      h_r   <= cam_href;
      d_r   <= cam_data;
      v_r_d <= v_r;
      h_r_d <= h_r;
    end
  end

`ifdef OV7670_CAPTURE_DECIMATE_EN
  logic sx_odd, sy_odd;

  // Source pixel / line parity; only even pixels on even lines are kept.
  always_ff @(posedge clk) begin
    if (reset || start_c) begin
      sx_odd <= 1'b0;
      sy_odd <= 1'b0;
    end else if (cap_c) begin
      if (flush_c) begin
        sx_odd <= 1'b0;
      end else if (pair_c) begin
        sx_odd <= ~sx_odd;
      end
      if (h_fall_c) begin
        sy_odd <= ~sy_odd;
      end
    end
  end

  // Keep decision and output-row advance for the decimated grid.
  always_comb begin
    keep_c   = ~sx_odd & ~sy_odd;
    y_step_c = h_fall_c & ~sy_odd;
  end
`else
  // Full resolution: every pair is a candidate and every line advances y.
  always_comb begin
    keep_c   = 1'b1;
    y_step_c = h_fall_c;
  end
`endif

  // Edge detection, capture qualifiers and range check.
  always_comb begin
    cap_c      = (state == CAPTURE) && config_done;
    v_fall_c   = v_r_d & ~v_r;
    v_rise_c   = ~v_r_d & v_r;
    h_fall_c   = h_r_d & ~h_r;
    start_c    = config_done && (state == WAIT_FRAME) && v_fall_c;
    flush_c    = cap_c & (h_fall_c | v_rise_c);
    in_range_c = (x_cnt < 10'(H_LIM)) && (y_cnt < 9'(V_LIM));
    accept_c   = in_range_c & keep_c;
    busy       = (state == CAPTURE);
  end

  ov7670_byte_pairer u_pairer (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_c),
    .enable        (cap_c & h_r),
    .flush         (flush_c),
    .accept        (accept_c),
    .d_r           (d_r),
    .pair_c        (pair_c),
    .partial_err_c (partial_err_c),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid)
  );

  // Frame state machine with coordinate, address and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      x_cnt       <= 10'd0;
      y_cnt       <= 9'd0;
      addr_cnt    <= '0;
      pixel_x     <= 10'd0;
      pixel_y     <= 9'd0;
      wr_addr     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      line_err    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (!config_done) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (capture_en) state <= WAIT_FRAME;
          end
          WAIT_FRAME: begin
            if (v_fall_c) begin
              state       <= CAPTURE;
              frame_start <= 1'b1;
              x_cnt       <= 10'd0;
              y_cnt       <= 9'd0;
              addr_cnt    <= '0;
              pixel_x     <= 10'd0;
              pixel_y     <= 9'd0;
              wr_addr     <= '0;
              line_err    <= 1'b0;
            end
          end
          CAPTURE: begin
            if (pair_c && accept_c) begin
              pixel_x  <= x_cnt;
              pixel_y  <= y_cnt;
              wr_addr  <= addr_cnt;
              x_cnt    <= x_cnt + 10'd1;
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            if (h_fall_c) begin
              x_cnt <= 10'd0;
            end
            if (y_step_c && (y_cnt < 9'(V_LIM - 1))) begin
              y_cnt <= y_cnt + 9'd1;
            end
            if (partial_err_c || (pair_c && keep_c && !in_range_c)) begin
              line_err <= 1'b1;
            end
            if (v_rise_c) state <= FRAME_END;
          end
          FRAME_END: begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            state       <= capture_en ? WAIT_FRAME : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture using a reduced 16x8 geometry.
module tb_ov7670_pixel_capture;

  localparam int unsigned H = 16;
  localparam int unsigned V = 8;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          reset, config_done, capture_en;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [9:0]    pixel_x;
  logic [8:0]    pixel_y;
  logic [AW-1:0] wr_addr;
  logic          frame_start, frame_done, line_err, busy;
  logic [7:0]    frame_count;

  int checks = 0;
  int failures = 0;

  int pv_cnt = 0, fs_cnt = 0, fd_cnt = 0;
  int last_x = 0, last_y = 0, last_addr = 0, last_data = 0;
  int pv0, fs0, fd0;

  always #5 clk = ~clk;

  ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .config_done (config_done),
    .capture_en  (capture_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .wr_addr     (wr_addr),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .line_err    (line_err),
    .busy        (busy)
  );

  // Event log sampled on the inactive edge.
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_cnt    = pv_cnt + 1;
      last_x    = int'(pixel_x);
      last_y    = int'(pixel_y);
      last_addr = int'(wr_addr);
      last_data = int'(pixel_data);
    end
    if (frame_start) fs_cnt = fs_cnt + 1;
    if (frame_done)  fd_cnt = fd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_href = 1'b1;
    cam_data = b;
    tick();
  endtask

  task automatic end_line();
    cam_href = 1'b0;
    cam_data = 8'h00;
    tick(3);
  endtask

  task automatic send_line(input int npix, input int base);
    for (int i = 0; i < 2 * npix; i++) send_byte(8'(base + i));
    end_line();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic start_frame();
    cam_vsync = 1'b1;
    tick(3);
    cam_vsync = 1'b0;
    tick(3);
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    tick(4);
  endtask

  task automatic run_full_frame(input int exp_pix, input int exp_last, input int exp_x, input int exp_y);
    start_frame();
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int l = 0; l < int'(V); l++) send_line(int'(H), l * 7);
    end_frame();
    check("full_pix_count", 32'(pv_cnt - pv0), 32'(exp_pix));
    check("full_last_addr", 32'(last_addr), 32'(exp_last));
    check("full_last_x", 32'(last_x), 32'(exp_x));
    check("full_last_y", 32'(last_y), 32'(exp_y));
    check("full_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("full_line_err", 32'(line_err), 32'd0);
  endtask

  initial begin
    reset = 1'b0; config_done = 1'b0; capture_en = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    tick();
    do_reset();
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);

    config_done = 1'b1;
    capture_en  = 1'b1;
`ifdef OV7670_CAPTURE_DECIMATE_EN
    run_full_frame(int'((H / 2) * (V / 2)), int'((H / 2) * (V / 2)) - 1, int'(H / 2) - 1, int'(V / 2) - 1);
    check("dec_frame_count", 32'(frame_count), 32'd1);
`else
    // First frame: start pulse timing and the A1 B2 C3 D4 line.
    cam_vsync = 1'b1;
    tick(3);
    fs0 = fs_cnt;
    cam_vsync = 1'b0;
    tick(2);
    check("t1_frame_start", 32'(frame_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    check("t1_p0_valid", 32'(pixel_valid), 32'd1);
    check("t1_p0_data", 32'(pixel_data), 32'h0000A1B2);
    check("t1_p0_xy_addr", {13'd0, pixel_x, pixel_y}, {13'd0, 10'd0, 9'd0});
    check("t1_p0_addr", 32'(wr_addr), 32'd0);
    send_byte(8'hD4);
    check("t1_strobe_width", 32'(pixel_valid), 32'd0);
    cam_href = 1'b0;
    tick();
    check("t1_p1_valid", 32'(pixel_valid), 32'd1);
    check("t1_p1_data", 32'(pixel_data), 32'h0000C3D4);
    check("t1_p1_x", 32'(pixel_x), 32'd1);
    check("t1_p1_addr", 32'(wr_addr), 32'd1);
    tick(2);
    check("t1_fs_once", 32'(fs_cnt - fs0), 32'd1);

    // Odd byte count line, then a following short line.
    pv0 = pv_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    end_line();
    check("odd_pix_count", 32'(pv_cnt - pv0), 32'd2);
    check("odd_line_err", 32'(line_err), 32'd1);
    check("odd_last_data", 32'(last_data), 32'h00000304);
    check("odd_last_addr", 32'(last_addr), 32'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    end_line();
    check("next_line_x", 32'(last_x), 32'd0);
    check("next_line_y", 32'(last_y), 32'd2);
    check("next_line_addr", 32'(last_addr), 32'd4);
    check("next_line_data", 32'(last_data), 32'h00001122);
    fd0 = fd_cnt;
    end_frame();
    check("f1_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("f1_frame_count", 32'(frame_count), 32'd1);
    check("f1_err_sticky", 32'(line_err), 32'd1);

    // Full frame; line_err cleared by its frame_start.
    cam_vsync = 1'b0;
    tick(3);
    check("f2_err_cleared", 32'(line_err), 32'd0);
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int l = 0; l < int'(V); l++) send_line(int'(H), l * 7);
    end_frame();
    check("full_pix_count", 32'(pv_cnt - pv0), 32'(H * V));
    check("full_last_addr", 32'(last_addr), 32'(H * V - 1));
    check("full_last_xy", {13'd0, 10'(last_x), 9'(last_y)}, {13'd0, 10'(H - 1), 9'(V - 1)});
    check("full_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("full_frame_count", 32'(frame_count), 32'd2);
    check("full_line_err", 32'(line_err), 32'd0);

    // Over-long line: extra pixel dropped and flagged.
    start_frame();
    pv0 = pv_cnt;
    send_line(int'(H) + 1, 0);
    check("long_pix_count", 32'(pv_cnt - pv0), 32'(H));
    check("long_line_err", 32'(line_err), 32'd1);
    end_frame();
    check("long_frame_count", 32'(frame_count), 32'd3);

    // Enabled mid-frame: wait for a fresh vsync before capturing.
    cam_vsync = 1'b0;
    do_reset();
    tick(3);
    pv0 = pv_cnt; fs0 = fs_cnt;
    send_line(2, 8'h40);
    check("mid_no_pixels", 32'(pv_cnt - pv0), 32'd0);
    check("mid_no_start", 32'(fs_cnt - fs0), 32'd0);
    start_frame();
    check("mid_start_after_vsync", 32'(fs_cnt - fs0), 32'd1);
    send_line(1, 8'h50);
    check("mid_one_pixel", 32'(pv_cnt - pv0), 32'd1);
    check("mid_pixel_data", 32'(last_data), 32'h00005051);

    // capture_en dropped mid-frame: frame finishes, then idle.
    capture_en = 1'b0;
    send_line(1, 8'h60);
    fd0 = fd_cnt; fs0 = fs_cnt;
    end_frame();
    check("drop_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("drop_frame_count", 32'(frame_count), 32'd1);
    check("drop_last_y", 32'(last_y), 32'd1);
    cam_vsync = 1'b0;
    tick(4);
    check("drop_no_restart", 32'(fs_cnt - fs0), 32'd0);
    check("drop_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a line.
    capture_en = 1'b1;
    tick(2);
    start_frame();
    send_byte(8'h71);
    send_byte(8'h72);
    send_byte(8'h73);
    send_byte(8'h74);
    fd0 = fd_cnt;
    reset = 1'b1;
    tick();
    check("mrst_outputs", {pixel_valid, busy, frame_start, frame_done, line_err, frame_count},
          13'd0);
    check("mrst_data_addr", {pixel_data, 7'(wr_addr), 9'(pixel_x)}, 32'd0);
    reset = 1'b0;
    cam_href = 1'b0;
    tick(4);
    check("mrst_no_done", 32'(fd_cnt - fd0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Downstream of the OV7670 register-setup stage; becomes active once that stage reports configuration done.
- Samples the camera's parallel bus (VSYNC, HREF, D[7:0]) and assembles byte pairs into RGB565 pixels.
- Emits each pixel with a valid strobe, x/y coordinates and a linear frame-buffer write address, and reports frame boundaries and bus errors.

Parameters:
- H_ACTIVE, 640, pixels per line accepted.
- V_ACTIVE, 480, lines per frame accepted.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  camera PCLK routed to fabric; all logic is on rising edge.
- reset  in  1  synchronous, active-high.
- config_done  in  1  level from the setup stage; capture is held off while low.
- capture_en  in  1  1 = capture frames; 0 = finish the current frame, then idle.
- cam_vsync  in  1  OV7670 VSYNC, high between frames.
- cam_href  in  1  OV7670 HREF, high during active bytes.
- cam_data  in  8  OV7670 D[7:0].
- pixel_data  out  16  RGB565 pixel; first byte of the pair is bits [15:8].
- pixel_valid  out  1  one-cycle strobe per pixel.
- pixel_x  out  10  column of pixel_data.
- pixel_y  out  9  row of pixel_data.
- wr_addr  out  ADDR_W  equals pixel_y*H_ACTIVE+pixel_x.
- frame_start  out  1  one-cycle pulse when a capture frame begins.
- frame_done  out  1  one-cycle pulse when a frame ends.
- frame_count  out  8  number of completed frames; wraps at 255->0.
- line_err  out  1  sticky flag: a line had an odd byte count or too many pixels; cleared at frame_start.
- busy  out  1  high in the CAPTURE state.

Behaviour:
- Reset: all outputs are 0; state is IDLE; byte phase is 0; input sample registers are 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (v_r, h_r, d_r). All decisions use the registered copies. Total latency from the second byte of a pair at the pins to pixel_valid is 2 cycles.
- Edge detect on v_r: a fall means vsync was 1 last cycle and 0 now; a rise means the opposite.
- State machine, one transition per cycle:
  - IDLE -> WAIT_FRAME when config_done && capture_en.
  - WAIT_FRAME -> CAPTURE on a v_r fall. frame_start pulses on that transition; x, y, wr_addr, byte phase and line_err are cleared. A capture never begins mid-frame.
  - CAPTURE -> FRAME_END on a v_r rise.
  - FRAME_END, one cycle: frame_done pulses and frame_count increments. Next state is WAIT_FRAME if capture_en, else IDLE.
  - Any state -> IDLE when config_done is low, with no pulses.
- Byte assembly in CAPTURE while h_r=1:
  - Phase 0: latch d_r as the high byte; phase becomes 1.
  - Phase 1: form the pixel {hi, d_r}; phase becomes 0; pixel_valid=1 on the next cycle with the current x, y and wr_addr.
  - After each valid pixel: x+1, wr_addr+1.
- Line end (h_r fall in CAPTURE):
  - x clears to 0; y+1, saturating at V_ACTIVE-1.
  - If phase=1, the partial byte is dropped, phase clears and line_err is set.
- Pixels with x >= H_ACTIVE or y >= V_ACTIVE are dropped: no pixel_valid, and line_err is set.
- wr_addr is produced by an incrementing counter, with no multiplier. It is held steady across line end so the next line continues contiguously.
- A v_r rise while h_r=1 aborts the line and follows the FRAME_END path. A partial pair is dropped and line_err is set.
- Simultaneous v_r rise and a phase-1 byte: the pixel is still emitted; FRAME_END follows.
- Reset mid-frame: immediate return to IDLE on the next edge with all outputs 0; no frame_done pulse.

Optional Feature:
- Macro: OV7670_CAPTURE_DECIMATE_EN.
- Defined: 2:1 decimation in both axes. Only even-numbered source pixels on even-numbered source lines produce pixel_valid, giving H_ACTIVE/2 x V_ACTIVE/2 output. x, y and wr_addr count output pixels, and range checks use the halved sizes.
- Undefined: full resolution, decimation logic absent.

Decomposition:
- Package ov7670_capture_pkg holds the state enum (IDLE, WAIT_FRAME, CAPTURE, FRAME_END) and the default H_ACTIVE/V_ACTIVE/ADDR_W constants.
- One natural sub-module, ov7670_byte_pairer: the phase toggle, high-byte latch, partial-pair error and pixel strobe.
- The top level keeps the input registers, edge detection, FSM, counters and decimation.

Test Plan:
- Reset, then config_done=1, capture_en=1, vsync 1->0, one line of 4 bytes A1 B2 C3 D4 -> frame_start once. Pixels 0xA1B2 at (0,0, addr 0) and 0xC3D4 at (1,0, addr 1). Each pixel_valid arrives 2 cycles after its second byte.
- Full 640x480 frame, then vsync rise -> exactly 307200 pixel_valid, last wr_addr=307199, one frame_done, frame_count=1, line_err=0.
- Line with 5 bytes -> 2 pixels emitted, line_err=1; next line starts at x=0, y+1; line_err cleared at the next frame_start.
- config_done=1, start stimulus with vsync already low mid-frame -> no pixels until the next vsync rise then fall.
- capture_en dropped mid-frame -> current frame completes with frame_done, state goes to IDLE, no further frame_start; assert reset mid-line -> all outputs 0 next cycle.
- With OV7670_CAPTURE_DECIMATE_EN, full frame -> 76800 valids, last address 76799, pixel_x max 319.
